// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetch_state_t;

    localparam int unsigned PC_STEP_DEFAULT      = 4;
    localparam int unsigned RESET_VECTOR_DEFAULT = 0;

endpackage

// File: rtl/instruction_fetch.sv
// Instruction fetch: reads the PC, fetches over req/gnt/rvalid, hands the word
// to decode over valid/ready, and steers the program counter's next value.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | out of reset, PC forced to the reset vector
// REQ   | mem_req high, mem_addr held until the memory grants
// WAIT  | request granted, waiting for rvalid (dropped if flush is set)
// HOLD  | instr/instr_pc valid to decode until accepted or redirected
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned PC_STEP      = PC_STEP_DEFAULT,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(RESET_VECTOR_DEFAULT)
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_next,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic              misalign_err
);

    fetch_state_t      state;
    fetch_state_t      state_nxt;
    logic              flush;
    logic              flush_nxt;
    logic              load_instr;
    logic              br_act;
    logic [ADDR_W-1:0] br_addr;

    // A redirect during IDLE is ignored so the first fetch always uses the
    // reset vector; the target is word-aligned by dropping the low bits.
    assign br_act  = br_taken && (state != IDLE);
    assign br_addr = {br_target[ADDR_W-1:2], 2'b00};

    assign mem_req     = (state == REQ);
    assign instr_valid = (state == HOLD);

    // Next PC mux: redirect, reset vector, sequential step on handoff, or hold.
    always_comb begin
        if (br_act) begin
            pc_next = br_addr;
        end else if (state == IDLE) begin
            pc_next = RESET_VECTOR;
        end else if ((state == HOLD) && instr_ready) begin
            pc_next = pc + ADDR_W'(PC_STEP);
        end else begin
            pc_next = pc;
        end
    end

    // Next-state logic; flush remembers that an outstanding response is stale.
    always_comb begin
        state_nxt  = state;
        flush_nxt  = flush;
        load_instr = 1'b0;
        case (state)
            IDLE: state_nxt = REQ;
            REQ: begin
                if (br_act) flush_nxt = 1'b1;
                if (mem_gnt) state_nxt = WAIT;
            end
            WAIT: begin
                if (mem_rvalid) begin
                    if (flush || br_act) begin
                        flush_nxt = 1'b0;
                        state_nxt = REQ;
                    end else begin
                        load_instr = 1'b1;
                        state_nxt  = HOLD;
                    end
                end else if (br_act) begin
                    flush_nxt = 1'b1;
                end
            end
            HOLD: begin
                if (br_act || instr_ready) state_nxt = REQ;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and flush registers.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state <= IDLE;
            flush <= 1'b0;
        end else begin
            state <= state_nxt;
            flush <= flush_nxt;
        end
    end

    // Fetch address loads on every entry to REQ, the same edge the PC takes pc_next.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            mem_addr <= RESET_VECTOR;
        end else if ((state_nxt == REQ) && (state != REQ)) begin
            mem_addr <= pc_next;
        end
    end

    // Capture the returned word and the address it came from.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            instr    <= '0;
            instr_pc <= '0;
        end else if (load_instr) begin
            instr    <= mem_rdata;
            instr_pc <= mem_addr;
        end
    end

    // One-cycle flag for a redirect target that is not word-aligned.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            misalign_err <= 1'b0;
        end else begin
            misalign_err <= br_act && (br_target[1:0] != 2'b00);
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a simple program-counter register.
module tb_instruction_fetch;

    logic        clk;
    logic        clr_n;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        br_taken;
    logic [31:0] br_target;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        misalign_err;

    int checks = 0;
    int errors = 0;

    instruction_fetch dut (
        .clk         (clk),
        .clr_n       (clr_n),
        .pc          (pc),
        .pc_next     (pc_next),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_gnt     (mem_gnt),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .misalign_err(misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program counter the fetch unit steers.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) pc <= 32'h0;
        else        pc <= pc_next;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clr_n = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        br_taken = 1'b0; br_target = 32'h0; instr_ready = 1'b0;
        tick(); tick();

        // reset state
        chk("rst_mem_req", 32'(mem_req), 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_instr_pc", instr_pc, 32'h0);
        chk("rst_valid", 32'(instr_valid), 32'h0);
        chk("rst_misalign", 32'(misalign_err), 32'h0);

        // first fetch from reset vector
        clr_n = 1'b1;
        #1;
        chk("idle_pc_next", pc_next, 32'h0);
        tick();
        chk("req_mem_req", 32'(mem_req), 32'h1);
        chk("req_mem_addr", mem_addr, 32'h0);
        chk("req_pc_next", pc_next, 32'h0);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        chk("wait_mem_req", 32'(mem_req), 32'h0);
        chk("wait_pc_next", pc_next, 32'h0);
        mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
        tick();
        mem_rvalid = 1'b0;
        instr_ready = 1'b1;
        #1;
        chk("hold_valid", 32'(instr_valid), 32'h1);
        chk("hold_instr", instr, 32'hDEADBEEF);
        chk("hold_instr_pc", instr_pc, 32'h0);
        chk("hold_pc_next", pc_next, 32'h4);
        tick();
        instr_ready = 1'b0;
        chk("seq_mem_addr", mem_addr, 32'h4);
        chk("seq_valid_drop", 32'(instr_valid), 32'h0);

        // grant delayed three cycles
        for (int i = 0; i < 4; i++) begin
            if (i == 3) mem_gnt = 1'b1;
            #1;
            chk("gnt_wait_req", 32'(mem_req), 32'h1);
            chk("gnt_wait_addr", mem_addr, 32'h4);
            chk("gnt_wait_pc_next", pc_next, 32'h4);
            tick();
        end
        mem_gnt = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h11111111;
        tick();
        mem_rvalid = 1'b0;

        // decode stalls five cycles
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", 32'(instr_valid), 32'h1);
            chk("stall_instr", instr, 32'h11111111);
            chk("stall_instr_pc", instr_pc, 32'h4);
            chk("stall_pc_next", pc_next, 32'h4);
            tick();
        end
        instr_ready = 1'b1;
        #1;
        chk("accept_pc_next", pc_next, 32'h8);
        tick();
        instr_ready = 1'b0;
        chk("accept_once_valid", 32'(instr_valid), 32'h0);
        chk("accept_mem_req", 32'(mem_req), 32'h1);
        chk("accept_mem_addr", mem_addr, 32'h8);

        // redirect while waiting: response discarded
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        br_taken = 1'b1; br_target = 32'h100;
        #1;
        chk("br_wait_pc_next", pc_next, 32'h100);
        tick();
        br_taken = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
        #1;
        chk("flush_pc_next", pc_next, 32'h100);
        tick();
        mem_rvalid = 1'b0;
        chk("flush_valid", 32'(instr_valid), 32'h0);
        chk("flush_instr_kept", instr, 32'h11111111);
        chk("flush_mem_req", 32'(mem_req), 32'h1);
        chk("flush_mem_addr", mem_addr, 32'h100);

        // misaligned redirect while holding
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
        tick();
        mem_rvalid = 1'b0;
        chk("br_hold_valid", 32'(instr_valid), 32'h1);
        chk("br_hold_instr_pc", instr_pc, 32'h100);
        br_taken = 1'b1; br_target = 32'h102;
        #1;
        chk("br_hold_pc_next", pc_next, 32'h100);
        chk("misalign_before", 32'(misalign_err), 32'h0);
        tick();
        br_taken = 1'b0;
        chk("misalign_pulse", 32'(misalign_err), 32'h1);
        chk("br_hold_valid_drop", 32'(instr_valid), 32'h0);
        chk("br_hold_mem_addr", mem_addr, 32'h100);
        tick();
        chk("misalign_clear", 32'(misalign_err), 32'h0);

        // sequential step wraps at the top of the address space
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'hA5A5A5A5;
        tick();
        mem_rvalid = 1'b0;
        br_taken = 1'b1; br_target = 32'hFFFFFFFC;
        tick();
        br_taken = 1'b0;
        chk("top_mem_addr", mem_addr, 32'hFFFFFFFC);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h0BADC0DE;
        tick();
        mem_rvalid = 1'b0;
        chk("top_instr", instr, 32'h0BADC0DE);
        chk("top_instr_pc", instr_pc, 32'hFFFFFFFC);
        instr_ready = 1'b1;
        #1;
        chk("wrap_pc_next", pc_next, 32'h0);
        tick();
        instr_ready = 1'b0;
        chk("wrap_mem_addr", mem_addr, 32'h0);

        // asynchronous reset in the middle of a wait
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        #2;
        clr_n = 1'b0;
        #1;
        chk("arst_mem_req", 32'(mem_req), 32'h0);
        chk("arst_mem_addr", mem_addr, 32'h0);
        chk("arst_instr", instr, 32'h0);
        chk("arst_instr_pc", instr_pc, 32'h0);
        chk("arst_valid", 32'(instr_valid), 32'h0);
        chk("arst_pc_next", pc_next, 32'h0);
        tick();
        #2;
        clr_n = 1'b1;
        mem_rvalid = 1'b1; mem_rdata = 32'hFFFF0000;
        tick();
        mem_rvalid = 1'b0;
        chk("post_rst_instr", instr, 32'h0);
        chk("post_rst_valid", 32'(instr_valid), 32'h0);
        chk("post_rst_req", 32'(mem_req), 32'h1);
        chk("post_rst_addr", mem_addr, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
